// File: rtl/ddr3_app_resp_model.sv
// Controller-side responder for the DDR3 app interface: command, write-data and
// read-data channels backed by a block-RAM array, with fixed read latency and optional ready throttling.
module ddr3_app_resp_model #(
    parameter int unsigned P_ADDR_W     = 27,
    parameter int unsigned P_DATA_W     = 256,
    parameter int unsigned P_MEM_AW     = 10,
    parameter int unsigned P_RD_LAT     = 8,
    parameter int unsigned P_INIT_CYC   = 64,
    parameter int unsigned P_RDY_PERIOD = 0
) (
    input  logic                i_ddr3_clk,
    input  logic                i_rst,
    input  logic [P_ADDR_W-1:0] i_app_addr,
    input  logic [2:0]          i_app_cmd,
    input  logic                i_app_en,
    output logic                o_app_rdy,
    input  logic [P_DATA_W-1:0] i_app_wdf_data,
    input  logic                i_app_wdf_wren,
    input  logic                i_app_wdf_end,
    output logic                o_app_wdf_rdy,
    output logic [P_DATA_W-1:0] o_app_rd_data,
    output logic                o_app_rd_data_valid,
    output logic                o_app_rd_data_end,
    output logic                o_init_calib_complete,
    output logic                o_cmd_err
);

    localparam int unsigned DEPTH      = 1 << P_MEM_AW;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_AW    = 2;
    localparam int unsigned FIFO_CW    = 3;
    localparam int unsigned INIT_W     = $clog2(P_INIT_CYC + 1);
    localparam int unsigned THR_W      = (P_RDY_PERIOD > 1) ? $clog2(P_RDY_PERIOD) : 1;
    localparam int unsigned THR_MAX    = (P_RDY_PERIOD > 1) ? P_RDY_PERIOD - 1 : 0;
    localparam logic [2:0]  CMD_WR     = 3'b000;
    localparam logic [2:0]  CMD_RD     = 3'b001;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [INIT_W-1:0]     init_cnt_q, init_cnt_d;
    logic [THR_W-1:0]      thr_cnt_q, thr_cnt_d;
    logic                  pend_q, pend_d;
    logic [P_MEM_AW-1:0]   pend_idx_q, pend_idx_d;
    logic [P_DATA_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [P_DATA_W-1:0]   fifo_d [FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [FIFO_CW-1:0]    cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  rdy_q, rdy_d;
    logic                  wdf_rdy_q, wdf_rdy_d;
    logic                  calib_q, calib_d;
    logic [P_RD_LAT-1:0]   vld_q, vld_d;
    logic [P_DATA_W-1:0]   dat_q [P_RD_LAT-1:1];
    logic [P_DATA_W-1:0]   dat_d [P_RD_LAT-1:1];

    logic [P_DATA_W-1:0]   mem [DEPTH];
    logic [P_DATA_W-1:0]   rd_raw_q;

    logic                  cmd_acc_c, beat_acc_c, wr_acc_c, rd_acc_c, ill_acc_c;
    logic [P_MEM_AW-1:0]   cmd_idx_c;
    logic                  push_c, pop_c, throttle_c;
    logic                  mem_we_c;
    logic [P_MEM_AW-1:0]   mem_widx_c;
    logic [P_DATA_W-1:0]   mem_wdata_c;
    logic                  unused_addr_bits;

    assign cmd_acc_c  = i_app_en & rdy_q;
    assign beat_acc_c = i_app_wdf_wren & wdf_rdy_q;
    assign wr_acc_c   = cmd_acc_c & (i_app_cmd == CMD_WR);
    assign rd_acc_c   = cmd_acc_c & (i_app_cmd == CMD_RD);
    assign ill_acc_c  = cmd_acc_c & (i_app_cmd != CMD_WR) & (i_app_cmd != CMD_RD);
    assign cmd_idx_c  = i_app_addr[P_MEM_AW+2:3];
    assign unused_addr_bits = ^{i_app_addr[2:0], i_app_addr[P_ADDR_W-1:P_MEM_AW+3]};

    // Next-state: init/throttle counters, write routing, FIFO, read pipeline, registered outputs
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        thr_cnt_d   = thr_cnt_q;
        pend_d      = pend_q;
        pend_idx_d  = pend_idx_q;
        fifo_d      = fifo_q;
        wp_d        = wp_q;
        rp_d        = rp_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        push_c      = 1'b0;
        pop_c       = 1'b0;
        mem_we_c    = 1'b0;
        mem_widx_c  = cmd_idx_c;
        mem_wdata_c = i_app_wdf_data;

        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + INIT_W'(1);
            if (init_cnt_q == INIT_W'(P_INIT_CYC - 1)) begin
                state_d = ST_RUN;
            end
        end else if (P_RDY_PERIOD > 1) begin
            thr_cnt_d = (thr_cnt_q == THR_W'(THR_MAX)) ? '0 : thr_cnt_q + THR_W'(1);
        end

        // A dataless write parks its index; the next beat lands there directly
        if (pend_q && beat_acc_c) begin
            mem_we_c   = 1'b1;
            mem_widx_c = pend_idx_q;
            pend_d     = 1'b0;
        end else if (wr_acc_c) begin
            if (cnt_q != '0) begin
                mem_we_c    = 1'b1;
                mem_wdata_c = fifo_q[rp_q];
                pop_c       = 1'b1;
                push_c      = beat_acc_c;
            end else if (beat_acc_c) begin
                mem_we_c = 1'b1;
            end else begin
                pend_d     = 1'b1;
                pend_idx_d = cmd_idx_c;
            end
        end else begin
            push_c = beat_acc_c;
        end

        if (push_c) begin
            fifo_d[wp_q] = i_app_wdf_data;
            wp_d         = wp_q + FIFO_AW'(1);
        end
        if (pop_c) begin
            rp_d = rp_q + FIFO_AW'(1);
        end
        cnt_d = cnt_q + FIFO_CW'(push_c) - FIFO_CW'(pop_c);

        err_d = err_q | ill_acc_c | (beat_acc_c & ~i_app_wdf_end);

        vld_d    = {vld_q[P_RD_LAT-2:0], rd_acc_c};
        dat_d[1] = vld_q[0] ? rd_raw_q : '0;
        for (int i = 2; i < P_RD_LAT; i++) begin
            dat_d[i] = dat_q[i-1];
        end

        throttle_c = (P_RDY_PERIOD > 1) && (thr_cnt_d == THR_W'(THR_MAX));
        rdy_d      = (state_d == ST_RUN) & ~pend_d & ~throttle_c;
        wdf_rdy_d  = (state_d == ST_RUN) & (cnt_d < FIFO_CW'(FIFO_DEPTH));
        calib_d    = (state_d == ST_RUN);
    end

    always_ff @(posedge i_ddr3_clk) begin
        if (i_rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            thr_cnt_q  <= '0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rdy_q      <= 1'b0;
            wdf_rdy_q  <= 1'b0;
            calib_q    <= 1'b0;
            vld_q      <= '0;
            for (int i = 1; i < P_RD_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            thr_cnt_q  <= thr_cnt_d;
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            fifo_q     <= fifo_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rdy_q      <= rdy_d;
            wdf_rdy_q  <= wdf_rdy_d;
            calib_q    <= calib_d;
            vld_q      <= vld_d;
            dat_q      <= dat_d;
        end
    end

    // Backing array; a write and a read never share an edge, so reads see prior writes
    always_ff @(posedge i_ddr3_clk) begin
        if (mem_we_c && !i_rst) begin
            mem[mem_widx_c] <= mem_wdata_c;
        end
        if (rd_acc_c) begin
            rd_raw_q <= mem[cmd_idx_c];
        end
    end

    assign o_app_rdy             = rdy_q;
    assign o_app_wdf_rdy         = wdf_rdy_q;
    assign o_app_rd_data         = dat_q[P_RD_LAT-1];
    assign o_app_rd_data_valid   = vld_q[P_RD_LAT-1];
    assign o_app_rd_data_end     = vld_q[P_RD_LAT-1];
    assign o_init_calib_complete = calib_q;
    assign o_cmd_err             = err_q;

endmodule

// File: tb/tb_ddr3_app_resp_model.sv
// Directed bench for ddr3_app_resp_model: init timing, write/read vectors,
// FIFO/pending corner cases, throttling on a second instance, error and mid-flight reset.
module tb_ddr3_app_resp_model;

    localparam int unsigned AW   = 27;
    localparam int unsigned DW   = 256;
    localparam int unsigned LAT  = 8;
    localparam int unsigned INIT = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] app_addr = '0;
    logic [2:0]    app_cmd = '0;
    logic          app_en = 1'b0;
    logic          app_rdy;
    logic [DW-1:0] wdf_data = '0;
    logic          wdf_wren = 1'b0;
    logic          wdf_end = 1'b0;
    logic          wdf_rdy;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_end, calib, cmd_err;

    logic [AW-1:0] z_addr = '0;
    logic [2:0]    z_cmd = '0;
    logic          z_bit = 1'b0;
    logic [DW-1:0] z_data = '0;
    logic          t_rdy, t_wdf_rdy, t_valid, t_end, t_calib, t_err;
    logic [DW-1:0] t_data;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    ddr3_app_resp_model #(.P_RDY_PERIOD(0)) dut (
        .i_ddr3_clk(clk), .i_rst(rst), .i_app_addr(app_addr), .i_app_cmd(app_cmd),
        .i_app_en(app_en), .o_app_rdy(app_rdy), .i_app_wdf_data(wdf_data),
        .i_app_wdf_wren(wdf_wren), .i_app_wdf_end(wdf_end), .o_app_wdf_rdy(wdf_rdy),
        .o_app_rd_data(rd_data), .o_app_rd_data_valid(rd_valid), .o_app_rd_data_end(rd_end),
        .o_init_calib_complete(calib), .o_cmd_err(cmd_err)
    );

    ddr3_app_resp_model #(.P_RDY_PERIOD(4)) dut_thr (
        .i_ddr3_clk(clk), .i_rst(rst), .i_app_addr(z_addr), .i_app_cmd(z_cmd),
        .i_app_en(z_bit), .o_app_rdy(t_rdy), .i_app_wdf_data(z_data),
        .i_app_wdf_wren(z_bit), .i_app_wdf_end(z_bit), .o_app_wdf_rdy(t_wdf_rdy),
        .o_app_rd_data(t_data), .o_app_rd_data_valid(t_valid), .o_app_rd_data_end(t_end),
        .o_init_calib_complete(t_calib), .o_cmd_err(t_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic do_cmd(input logic [2:0] c, input logic [AW-1:0] a, input bit wd,
                          input logic [DW-1:0] d, output int acc);
        bit done = 1'b0;
        acc = -1;
        app_en = 1'b1; app_cmd = c; app_addr = a;
        wdf_wren = wd; wdf_end = wd; wdf_data = d;
        for (int i = 0; i < 20 && !done; i++) begin
            if (app_rdy && (!wd || wdf_rdy)) begin
                acc  = cyc;
                done = 1'b1;
            end
            @(negedge clk);
        end
        app_en = 1'b0; wdf_wren = 1'b0; wdf_end = 1'b0;
        if (!done) chk("cmd_accept_timeout", 0, 1);
    endtask

    task automatic wait_rd(input int acc, input logic [DW-1:0] exp, input string name);
        int t = -1;
        for (int i = 0; i < 30 && t < 0; i++) begin
            if (rd_valid) begin
                t = cyc;
                chk({name, "_data"}, rd_data, exp);
                chk({name, "_end"}, rd_end, 1);
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
        chk({name, "_latency"}, DW'(t - acc), DW'(LAT));
    endtask

    typedef struct packed {
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] raddr;
        logic [DW-1:0] exp;
    } vec_t;

    initial begin
        vec_t          vecs [4];
        logic [DW-1:0] dv [4];
        logic [DW-1:0] dp;
        int            acc, acc0, t;
        bit            seen;

        vecs[0] = '{27'h10,      {32{8'hA5}},           27'h10,   {32{8'hA5}}};
        vecs[1] = '{27'h2000,    {8{32'hDEADBEEF}},     27'h0,    {8{32'hDEADBEEF}}};
        vecs[2] = '{27'h48,      {4{64'h0123456789ABCDEF}}, 27'h4F, {4{64'h0123456789ABCDEF}}};
        vecs[3] = '{27'h7FFFFF8, {16{16'h5A3C}},        27'h1FF8, {16{16'h5A3C}}};
        for (int i = 0; i < 4; i++) dv[i] = {8{32'hC0DE0000 + 32'(i)}};
        dp = {8{32'hFACE0020}};

        repeat (3) @(negedge clk);
        chk("reset_ctl", {rd_valid, rd_end, calib, app_rdy, wdf_rdy, cmd_err}, 0);
        chk("reset_data", rd_data, 0);

        // Init window and throttle pattern on the second instance
        rst = 1'b0;
        for (int k = 0; k < 76; k++) begin
            chk($sformatf("init_c%0d", k), {calib, app_rdy, wdf_rdy}, (k >= 64) ? 3'b111 : 3'b000);
            chk($sformatf("thr_rdy_c%0d", k), t_rdy, (k >= 64) && (((k - 64) % 4) != 3));
            chk($sformatf("init_noval_c%0d", k), rd_valid, 0);
            @(negedge clk);
        end

        // Table: write with data, then read in the next accept
        for (int i = 0; i < 4; i++) begin
            do_cmd(3'b000, vecs[i].waddr, 1'b1, vecs[i].wdata, acc);
            do_cmd(3'b001, vecs[i].raddr, 1'b0, '0, acc);
            wait_rd(acc, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Data ahead of commands fills the FIFO
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fifo_rdy_%0d", i), wdf_rdy, 1);
            wdf_wren = 1'b1; wdf_end = 1'b1; wdf_data = dv[i];
            @(negedge clk);
        end
        wdf_wren = 1'b0; wdf_end = 1'b0;
        chk("fifo_full", wdf_rdy, 0);
        do_cmd(3'b000, 27'h00, 1'b0, '0, acc);
        chk("fifo_pop_rdy", wdf_rdy, 1);
        do_cmd(3'b000, 27'h08, 1'b0, '0, acc);
        do_cmd(3'b000, 27'h10, 1'b0, '0, acc);
        do_cmd(3'b000, 27'h18, 1'b0, '0, acc);
        chk("fifo_drained_rdy", {app_rdy, wdf_rdy}, 2'b11);
        acc0 = cyc;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_rdy_%0d", i), app_rdy, 1);
            app_en = 1'b1; app_cmd = 3'b001; app_addr = AW'(i * 8);
            @(negedge clk);
        end
        app_en = 1'b0;
        t = -1;
        for (int i = 0; i < 20 && t < 0; i++) begin
            if (rd_valid) t = cyc;
            else @(negedge clk);
        end
        chk("b2b_latency", DW'(t - acc0), DW'(LAT));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b2b_valid_%0d", i), {rd_valid, rd_end}, 2'b11);
            chk($sformatf("b2b_data_%0d", i), rd_data, dv[i]);
            @(negedge clk);
        end
        chk("b2b_after", rd_valid, 0);

        // Command ahead of data parks a pending write
        do_cmd(3'b000, 27'h20, 1'b0, '0, acc);
        chk("pend_rdy_low1", app_rdy, 0);
        @(negedge clk);
        chk("pend_rdy_low2", app_rdy, 0);
        @(negedge clk);
        chk("pend_wdf_rdy", wdf_rdy, 1);
        wdf_wren = 1'b1; wdf_end = 1'b1; wdf_data = dp;
        @(negedge clk);
        wdf_wren = 1'b0; wdf_end = 1'b0;
        chk("pend_rdy_restore", app_rdy, 1);
        do_cmd(3'b001, 27'h20, 1'b0, '0, acc);
        wait_rd(acc, dp, "pend_rd");

        // Illegal command sets a sticky error
        chk("err_clear", cmd_err, 0);
        do_cmd(3'b010, 27'h30, 1'b0, '0, acc);
        chk("err_set", cmd_err, 1);
        repeat (5) @(negedge clk);
        chk("err_sticky", {cmd_err, rd_valid}, 2'b10);

        // Reset with three reads in flight
        for (int i = 0; i < 3; i++) begin
            app_en = 1'b1; app_cmd = 3'b001; app_addr = 27'h10;
            @(negedge clk);
        end
        app_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ctl", {rd_valid, rd_end, calib, app_rdy, wdf_rdy, cmd_err}, 0);
        chk("rst_data", rd_data, 0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (rd_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("rst_no_valid", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr3_app_resp_model.md
# ddr3_app_resp_model

Synthesizable responder for the DDR3 controller user (app) interface. It plays the controller side of the command, write-data and read-data channels that the frame-buffer write/read engines and arbiter drive. It backs requests with a block-RAM array and has configurable read latency and ready throttling. It substitutes for the real controller in simulation and in on-board loopback builds of the frame-buffer path.

## Interface
- P_ADDR_W, 27, app address width
- P_DATA_W, 256, app data width (one beat = one BL8 burst)
- P_MEM_AW, 10, log2 of backing-array depth in beats
- P_RD_LAT, 8, accept-to-read-data latency in cycles (>=2)
- P_INIT_CYC, 64, cycles after reset before calibration-complete
- P_RDY_PERIOD, 0, 0 = no throttling; N>1 = o_app_rdy forced low one cycle in every N

Ports:
- i_ddr3_clk  in  1  sole clock
- i_rst  in  1  reset: synchronous, active-high
- i_app_addr  in  P_ADDR_W  command address
- i_app_cmd  in  3  3'b000 write, 3'b001 read, others illegal
- i_app_en  in  1  command valid
- o_app_rdy  out  1  command ready
- i_app_wdf_data  in  P_DATA_W  write data
- i_app_wdf_wren  in  1  write data valid
- i_app_wdf_end  in  1  last beat (always equals wren; checked)
- o_app_wdf_rdy  out  1  write-data ready
- o_app_rd_data  out  P_DATA_W  read data
- o_app_rd_data_valid  out  1  read data valid
- o_app_rd_data_end  out  1  last beat; equals valid
- o_init_calib_complete  out  1  calibration done
- o_cmd_err  out  1  sticky: illegal cmd, or wren without end

## Operation
- Top FSM: INIT -> RUN. INIT counts P_INIT_CYC cycles; in INIT, o_app_rdy=o_app_wdf_rdy=0.
- RUN -> INIT only by reset.
- Command accepted when i_app_en & o_app_rdy. Write beat accepted when i_app_wdf_wren & o_app_wdf_rdy.
- Beat index = i_app_addr[P_MEM_AW+2:3]. Bits [2:0] and bits above the index are ignored, so addresses alias modulo depth.
- Write-data FIFO, 4 beats deep. o_app_wdf_rdy = RUN & count<4. Data may lead its command by up to 4 beats.
- Write command:
  - If FIFO nonempty, or a beat arrives the same cycle, the head beat is written to the array in the accept cycle.
  - Otherwise the command goes into a pending register and o_app_rdy drops.
  - When the next beat arrives, it is written to the pending address and pending clears.
- Read command: array read at the index, result pushed into a P_RD_LAT-stage valid/data pipeline. Reads stay strictly in order.
- Write then read of the same index in consecutive accepts: the read returns the new data (write-first).
- Illegal cmd: accepted, no effect, sets o_cmd_err.
- Throttle: free-running counter mod P_RDY_PERIOD, running in RUN. o_app_rdy = RUN & !pending & !(cnt==P_RDY_PERIOD-1).
- Array contents are not cleared by reset; they are zero at configuration.

## Timing
- All outputs are registered.
- Reset values: o_app_rdy=0, o_app_wdf_rdy=0, o_app_rd_data_valid=0, o_app_rd_data_end=0, o_app_rd_data=0, o_init_calib_complete=0, o_cmd_err=0.
- Reset mid-operation: the FIFO, pending register and read pipeline are flushed. Read beats in flight are discarded, with no valid after reset.
- o_init_calib_complete rises P_INIT_CYC cycles after i_rst deasserts. o_app_rdy and o_app_wdf_rdy rise in the same cycle.
- Read latency: a command accepted at cycle T gives o_app_rd_data_valid at T+P_RD_LAT. Back-to-back reads give back-to-back valids.
- Pending write: o_app_rdy goes low at T+1 after the dataless accept at T. If data arrives at cycle D, o_app_rdy goes high at D+1.
- FIFO full: o_app_wdf_rdy is low from the cycle after the 4th beat until the cycle after a pop.
- Simultaneous write-command accept and beat accept with an empty FIFO: the beat bypasses the FIFO directly into the array.

## Test plan
- Init: deassert i_rst. Calib, rdy and wdf_rdy stay 0 for 64 cycles, then all read 1 at cycle 64. No rd_valid.
- Write/read: write 0xA5..A5 to addr 0x10, then read addr 0x10. Valid arrives exactly 8 cycles after the read accept, data = 0xA5..A5, end = valid.
- Data-before-command: 4 beats D0..D3 with no command. wdf_rdy then drops. Writes to addr 0x00, 0x08, 0x10, 0x18 then store D0..D3. Readback is in order and back-to-back.
- Command-before-data: write cmd to addr 0x20 with no beat. rdy drops next cycle. A beat 3 cycles later restores rdy, and readback of 0x20 matches.
- Throttle and aliasing: with P_RDY_PERIOD=4, rdy is low every 4th cycle. A write to index 0x400 (P_MEM_AW=10) reads back at index 0.
- Errors and reset: cmd=3'b010 sets o_cmd_err, which stays set. i_rst asserted with 3 reads in flight produces no rd_valid afterward, and all outputs return to 0.
